// File: rtl/br_pkg.sv
// Shared definitions for the instruction issuer: instruction field layout and FSM states.
package br_pkg;
    localparam int unsigned AW_LSB  = 0;
    localparam int unsigned AR1_LSB = 5;
    localparam int unsigned AR2_LSB = 10;
    localparam int unsigned OP_LSB  = 15;
    localparam int unsigned FIELD_W = 5;
    localparam int unsigned INSTR_W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } br_state_t;
endpackage

// File: rtl/br_prog_mem.sv
// Program memory: one synchronous write port, read port registered straight into the bus.
module br_prog_mem
    import br_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_we,
    input  logic [PC_W-1:0]    i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic               i_re,
    input  logic [PC_W-1:0]    i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_rdata;

    // Contents are deliberately not reset so a program survives rst_n.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/br_instr_issuer.sv
// Instruction issuer: preloaded program words streamed to the datapath over valid/ready.
//   state | meaning
//   IDLE  | stopped; program memory writable
//   RUN   | issuing words, bus_valid may be high
//   DONE  | program finished; memory writable, start restarts
module br_instr_issuer
    import br_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load_en,
    input  logic [PC_W-1:0]    i_load_addr,
    input  logic [INSTR_W-1:0] i_load_data,
    input  logic [PC_W:0]      i_prog_len,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_loop_en,
    input  logic               i_bus_ready,
    output logic [INSTR_W-1:0] o_bus,
    output logic               o_bus_valid,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_issued_cnt
);
    localparam logic [PC_W:0]    DEPTH_L = (PC_W+1)'(DEPTH);
    localparam logic [PC_W:0]    LEN_ONE = (PC_W+1)'(1);
    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    br_state_t          r_state, w_state_nxt;
    logic [PC_W-1:0]    r_pc, w_pc_nxt;
    logic [PC_W:0]      r_len, w_len_nxt, w_len_eff;
    logic               r_valid, w_valid_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_busy, r_done;
    logic               w_xfer, w_last, w_rd_en, w_we;
    logic [PC_W-1:0]    w_rd_addr;

    assign w_len_eff = (i_prog_len > DEPTH_L) ? DEPTH_L : i_prog_len;
    assign w_xfer    = r_valid && i_bus_ready;
    assign w_last    = ({1'b0, r_pc} == (r_len - LEN_ONE));
    assign w_we      = i_load_en && (r_state != RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_len_nxt   = r_len;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        case (r_state)
            IDLE, DONE: begin
                if (i_stop) begin
                    w_state_nxt = IDLE;
                end else if (i_start) begin
                    w_len_nxt = w_len_eff;
                    w_cnt_nxt = '0;
                    w_pc_nxt  = '0;
                    if (w_len_eff != '0) begin
                        w_state_nxt = RUN;
                        w_valid_nxt = 1'b1;
                        w_rd_en     = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (w_xfer && !(&r_cnt)) w_cnt_nxt = r_cnt + CNT_ONE;
                // A stalled word is simply dropped on stop.
                if (i_stop) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                end else if (w_xfer) begin
                    if (!w_last) begin
                        w_pc_nxt  = r_pc + PC_ONE;
                        w_rd_en   = 1'b1;
                        w_rd_addr = r_pc + PC_ONE;
                    end else if (i_loop_en) begin
                        w_pc_nxt = '0;
                        w_rd_en  = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = DONE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_len   <= w_len_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    br_prog_mem #(.DEPTH(DEPTH), .PC_W(PC_W)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (o_bus)
    );

    assign o_bus_valid  = r_valid;
    assign o_pc         = r_pc;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_issued_cnt = r_cnt;
endmodule

// File: tb/tb_br_instr_issuer.sv
// Scoreboard bench for br_instr_issuer: expected {pc, word} pairs queued by stimulus, checked by a monitor.
module tb_br_instr_issuer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [19:0] load_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        bus_ready = 1'b0;
    logic [19:0] bus;
    logic        bus_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic [15:0] issued_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] sb_q[$];
    logic [19:0] tb_mem [16];

    br_instr_issuer #(.DEPTH(16), .PC_W(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_en    (load_en),
        .i_load_addr  (load_addr),
        .i_load_data  (load_data),
        .i_prog_len   (prog_len),
        .i_start      (start),
        .i_stop       (stop),
        .i_loop_en    (loop_en),
        .i_bus_ready  (bus_ready),
        .o_bus        (bus),
        .o_bus_valid  (bus_valid),
        .o_pc         (pc),
        .o_busy       (busy),
        .o_done       (done),
        .o_issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus_valid && bus_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_xfer_pc", 32'(pc), 32'hFFFF_FFFF);
            end else begin
                logic [23:0] e;
                e = sb_q.pop_front();
                chk("xfer_pc", 32'(pc), 32'(e[23:20]));
                chk("xfer_bus", 32'(bus), 32'(e[19:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [19:0] data);
        load_en   = 1'b1;
        load_addr = 4'(addr);
        load_data = data;
        tb_mem[addr] = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back({4'(first + i), tb_mem[first + i]});
    endtask

    task automatic do_start(input int len);
        prog_len = 5'(len);
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            tick();
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        #1;
        chk("rst_bus", 32'(bus), 32'd0);
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(issued_cnt), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Basic three-word program, always ready
        load(0, 20'h0_8421);
        load(1, 20'h1_0C62);
        load(2, 20'h2_14A3);
        bus_ready = 1'b1;
        push_words(0, 3);
        do_start(3);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done", 40);
        chk("t1_valid", 32'(bus_valid), 32'd0);
        chk("t1_cnt", 32'(issued_cnt), 32'd3);

        // Back-pressure on word 1
        push_words(0, 3);
        do_start(3);
        tick();
        bus_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t2_hold_bus", 32'(bus), 32'h1_0C62);
            chk("t2_hold_pc", 32'(pc), 32'd1);
            if (k < 2) tick();
        end
        bus_ready = 1'b1;
        wait_done("t2_done", 40);
        chk("t2_cnt", 32'(issued_cnt), 32'd3);

        // Looping two-word program, stop coincides with the 7th transfer
        loop_en = 1'b1;
        for (int k = 0; k < 7; k++) sb_q.push_back({4'(k % 2), tb_mem[k % 2]});
        do_start(2);
        repeat (6) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
        chk("t3_valid", 32'(bus_valid), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_cnt", 32'(issued_cnt), 32'd7);

        // Zero-length program
        do_start(0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_cnt", 32'(issued_cnt), 32'd0);
        begin
            logic seen;
            seen = bus_valid;
            repeat (3) begin
                tick();
                seen = seen | bus_valid;
            end
            chk("t4_never_valid", 32'(seen), 32'd0);
        end

        // Oversized length clamps to DEPTH
        for (int a = 3; a < 16; a++) load(a, 20'hA_0000 + 20'(a * 20'h111));
        push_words(0, 16);
        do_start(20);
        wait_done("t5_done", 60);
        chk("t5_cnt", 32'(issued_cnt), 32'd16);

        // Writes during RUN are ignored
        bus_ready = 1'b0;
        push_words(0, 3);
        do_start(3);
        load_en   = 1'b1;
        load_addr = 4'd1;
        load_data = 20'hF_FFFF;
        tick();
        load_en   = 1'b0;
        bus_ready = 1'b1;
        wait_done("t6_done", 40);
        chk("t6_cnt", 32'(issued_cnt), 32'd3);

        // stop and start together: stop wins
        prog_len = 5'd3;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_done", 32'(done), 32'd0);
        tick();
        chk("t7_valid", 32'(bus_valid), 32'd0);

        // Asynchronous reset mid-run
        push_words(0, 1);
        do_start(3);
        tick();
        bus_ready = 1'b0;
        chk("t8_pre_cnt", 32'(issued_cnt), 32'd1);
        chk("t8_pre_pc", 32'(pc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t8_rst_bus", 32'(bus), 32'd0);
        chk("t8_rst_valid", 32'(bus_valid), 32'd0);
        chk("t8_rst_pc", 32'(pc), 32'd0);
        chk("t8_rst_busy", 32'(busy), 32'd0);
        chk("t8_rst_cnt", 32'(issued_cnt), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        bus_ready = 1'b1;
        push_words(0, 3);
        do_start(3);
        wait_done("t8_done", 40);
        chk("t8_cnt", 32'(issued_cnt), 32'd3);

        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
